// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: sequencer for a row of N systolic PEs (clear, stream, skewed fire, drain, output select).
// Optional feature: define PE_SEQ_STALL_EN to add a stall input that pauses operand streaming.
module pe_seq_ctrl #(
    parameter int N      = 4,
    parameter int K_W    = 8,
    parameter int PE_LAT = 1,
    parameter int SEL_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [K_W-1:0]   k_len,
`ifdef PE_SEQ_STALL_EN
    input  logic             stall,
`endif
    output logic             busy,
    output logic             done,
    output logic             clr,
    output logic             rd_en,
    output logic [K_W-1:0]   rd_addr,
    output logic [N-1:0]     fire,
    output logic             out_valid,
    output logic [SEL_W-1:0] out_sel
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] STREAM = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] OUT    = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam int CW_MIN = $clog2(N + PE_LAT + 1);
    localparam int CW     = CW_MIN > SEL_W ? CW_MIN : SEL_W;

    logic [2:0]     state_q, state_d;
    logic [K_W-1:0] klen_q, klen_d;
    logic [K_W-1:0] addr_q, addr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   fire_q, fire_d;
    logic           stall_w;

`ifdef PE_SEQ_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign clr       = state_q == CLEAR;
    assign rd_en     = (state_q == STREAM) && !stall_w;
    assign rd_addr   = addr_q;
    assign fire      = fire_q;
    assign out_valid = state_q == OUT;
    assign out_sel   = out_valid ? SEL_W'(cnt_q) : '0;

    // Next-state: tile phases; the stream counter only advances on real reads and ends at the latched k_len
    always_comb begin
        state_d = state_q;
        klen_d  = klen_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        fire_d  = (fire_q << 1) | N'(rd_en);
        case (state_q)
            IDLE: begin
                if (start) begin
                    klen_d  = k_len;
                    addr_d  = '0;
                    cnt_d   = '0;
                    state_d = (k_len == '0) ? DONE : CLEAR;
                end
            end
            CLEAR: state_d = STREAM;
            STREAM: begin
                if (rd_en) begin
                    addr_d = addr_q + 1'b1;
                    if (addr_q == klen_q - 1'b1) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N + PE_LAT - 1)) begin
                    state_d = OUT;
                    cnt_d   = '0;
                end
            end
            OUT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any tile without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            klen_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            fire_q  <= '0;
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            fire_q  <= fire_d;
        end
    end
endmodule
